// File: rtl/axi_arb_pkg.sv
// axi_arb_pkg: shared FSM encoding and AXI response codes for axi_lite_arbiter
package axi_arb_pkg;
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP} state_t;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester round-robin pick; on a tie the master not served last wins
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_idx
);
  assign gnt_idx = &req ? ~last : req[1];
endmodule

// File: rtl/axi_lite_arbiter.sv
// axi_lite_arbiter: two-master to one-slave AXI4-Lite arbiter, one transaction at a time.
// Define ARB_TIMEOUT_EN to fabricate a DECERR response after TIMEOUT_CYCLES of response wait.
module axi_lite_arbiter
  import axi_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] m0_araddr,
  input  logic [2:0]  m0_arprot,
  input  logic        m0_arvalid,
  output logic        m0_arready,
  output logic [31:0] m0_rdata,
  output logic [1:0]  m0_rresp,
  output logic        m0_rvalid,
  input  logic        m0_rready,
  input  logic [31:0] m0_awaddr,
  input  logic [2:0]  m0_awprot,
  input  logic        m0_awvalid,
  output logic        m0_awready,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  input  logic        m0_wvalid,
  output logic        m0_wready,
  output logic [1:0]  m0_bresp,
  output logic        m0_bvalid,
  input  logic        m0_bready,
  input  logic [31:0] m1_araddr,
  input  logic [2:0]  m1_arprot,
  input  logic        m1_arvalid,
  output logic        m1_arready,
  output logic [31:0] m1_rdata,
  output logic [1:0]  m1_rresp,
  output logic        m1_rvalid,
  input  logic        m1_rready,
  input  logic [31:0] m1_awaddr,
  input  logic [2:0]  m1_awprot,
  input  logic        m1_awvalid,
  output logic        m1_awready,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  input  logic        m1_wvalid,
  output logic        m1_wready,
  output logic [1:0]  m1_bresp,
  output logic        m1_bvalid,
  input  logic        m1_bready,
  output logic [31:0] s_araddr,
  output logic [2:0]  s_arprot,
  output logic        s_arvalid,
  input  logic        s_arready,
  input  logic [31:0] s_rdata,
  input  logic [1:0]  s_rresp,
  input  logic        s_rvalid,
  output logic        s_rready,
  output logic [31:0] s_awaddr,
  output logic [2:0]  s_awprot,
  output logic        s_awvalid,
  input  logic        s_awready,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  output logic        s_wvalid,
  input  logic        s_wready,
  input  logic [1:0]  s_bresp,
  input  logic        s_bvalid,
  output logic        s_bready,
  output logic        grant,
  output logic        busy
);
  state_t state, next_state;
  logic last, next_last, next_grant, aw_done, w_done, next_aw_done, next_w_done;
  logic gnt_idx, tmo, idle, rd_a, rd_d, wr_a, wr_r;
  logic g_arvalid, g_awvalid, g_wvalid, g_rready, g_bready;
  logic ar_hs, aw_hs, w_hs, r_hs, b_hs, r_valid, b_valid;
  logic [1:0] rd_req, wr_req;
  logic [31:0] r_data;
  logic [1:0] r_resp, b_resp;
  assign rd_req = {m1_arvalid, m0_arvalid};
  assign wr_req = {m1_awvalid & m1_wvalid, m0_awvalid & m0_wvalid};
  rr_arb2 u_rr (.req(rd_req | wr_req), .last(last), .gnt_idx(gnt_idx));
  assign idle = state == IDLE;
  assign rd_a = state == RD_ADDR;
  assign rd_d = state == RD_DATA;
  assign wr_a = state == WR_ADDR;
  assign wr_r = state == WR_RESP;
  assign busy = !idle;
  assign g_arvalid = grant ? m1_arvalid : m0_arvalid;
  assign g_awvalid = grant ? m1_awvalid : m0_awvalid;
  assign g_wvalid  = grant ? m1_wvalid  : m0_wvalid;
  assign g_rready  = grant ? m1_rready  : m0_rready;
  assign g_bready  = grant ? m1_bready  : m0_bready;
  assign s_araddr  = grant ? m1_araddr  : m0_araddr;
  assign s_arprot  = grant ? m1_arprot  : m0_arprot;
  assign s_awaddr  = grant ? m1_awaddr  : m0_awaddr;
  assign s_awprot  = grant ? m1_awprot  : m0_awprot;
  assign s_wdata   = grant ? m1_wdata   : m0_wdata;
  assign s_wstrb   = grant ? m1_wstrb   : m0_wstrb;
  assign s_arvalid = rd_a & g_arvalid;
  assign s_awvalid = wr_a & !aw_done & g_awvalid;
  assign s_wvalid  = wr_a & !w_done & g_wvalid;
  assign s_rready  = idle | (rd_d & !tmo & g_rready);
  assign s_bready  = idle | (wr_r & !tmo & g_bready);
  assign r_valid = rd_d & (tmo | s_rvalid);
  assign b_valid = wr_r & (tmo | s_bvalid);
  assign r_data  = tmo ? '0 : s_rdata;
  assign r_resp  = tmo ? RESP_DECERR : s_rresp;
  assign b_resp  = tmo ? RESP_DECERR : s_bresp;
  assign ar_hs = s_arvalid & s_arready;
  assign aw_hs = s_awvalid & s_awready;
  assign w_hs  = s_wvalid & s_wready;
  assign r_hs  = r_valid & g_rready;
  assign b_hs  = b_valid & g_bready;
  assign m0_arready = !grant & rd_a & s_arready;
  assign m1_arready =  grant & rd_a & s_arready;
  assign m0_awready = !grant & wr_a & !aw_done & s_awready;
  assign m1_awready =  grant & wr_a & !aw_done & s_awready;
  assign m0_wready  = !grant & wr_a & !w_done & s_wready;
  assign m1_wready  =  grant & wr_a & !w_done & s_wready;
  assign m0_rvalid  = !grant & r_valid;
  assign m1_rvalid  =  grant & r_valid;
  assign m0_bvalid  = !grant & b_valid;
  assign m1_bvalid  =  grant & b_valid;
  assign m0_rdata = r_data;
  assign m1_rdata = r_data;
  assign m0_rresp = r_resp;
  assign m1_rresp = r_resp;
  assign m0_bresp = b_resp;
  assign m1_bresp = b_resp;
`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] cnt;
  logic sat;
  assign sat = cnt == CW'(TIMEOUT_CYCLES);
  assign tmo = (rd_d | wr_r) & sat;
  always_ff @(posedge clk)
    if (rst || next_state != state) cnt <= '0;
    else if (!sat) cnt <= cnt + 1'b1;
`else
  logic unused_cfg;
  assign unused_cfg = |TIMEOUT_CYCLES;
  assign tmo = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      last    <= 1'b1;
      grant   <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state   <= next_state;
      last    <= next_last;
      grant   <= next_grant;
      aw_done <= next_aw_done;
      w_done  <= next_w_done;
    end
  end
  always_comb begin
    next_state   = state;
    next_last    = last;
    next_grant   = grant;
    next_aw_done = aw_done;
    next_w_done  = w_done;
    case (state)
      IDLE: if (|(rd_req | wr_req)) begin
        next_grant = gnt_idx;
        next_state = wr_req[gnt_idx] ? WR_ADDR : RD_ADDR;
      end
      RD_ADDR: next_state = ar_hs ? RD_DATA : RD_ADDR;
      RD_DATA: if (r_hs) begin
        next_last  = grant;
        next_state = IDLE;
      end
      WR_ADDR: begin
        next_aw_done = aw_done | aw_hs;
        next_w_done  = w_done | w_hs;
        if (next_aw_done && next_w_done) begin
          next_aw_done = 1'b0;
          next_w_done  = 1'b0;
          next_state   = WR_RESP;
        end
      end
      WR_RESP: if (b_hs) begin
        next_last  = grant;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end
endmodule

// File: tb/tb_axi_lite_arbiter.sv
// tb_axi_lite_arbiter: directed self-checking bench for axi_lite_arbiter (timeout case under ARB_TIMEOUT_EN)
module tb_axi_lite_arbiter;
  import axi_arb_pkg::*;
  logic clk = 0, rst = 1;
  logic [31:0] m0_araddr = 0, m0_rdata, m0_awaddr = 0, m0_wdata = 0;
  logic [2:0]  m0_arprot = 0, m0_awprot = 0;
  logic [3:0]  m0_wstrb = 0;
  logic [1:0]  m0_rresp, m0_bresp;
  logic m0_arvalid = 0, m0_arready, m0_rvalid, m0_rready = 1, m0_awvalid = 0, m0_awready;
  logic m0_wvalid = 0, m0_wready, m0_bvalid, m0_bready = 1;
  logic [31:0] m1_araddr = 0, m1_rdata, m1_awaddr = 0, m1_wdata = 0;
  logic [2:0]  m1_arprot = 0, m1_awprot = 0;
  logic [3:0]  m1_wstrb = 0;
  logic [1:0]  m1_rresp, m1_bresp;
  logic m1_arvalid = 0, m1_arready, m1_rvalid, m1_rready = 1, m1_awvalid = 0, m1_awready;
  logic m1_wvalid = 0, m1_wready, m1_bvalid, m1_bready = 1;
  logic [31:0] s_araddr, s_rdata = 0, s_awaddr, s_wdata;
  logic [2:0]  s_arprot, s_awprot;
  logic [3:0]  s_wstrb;
  logic [1:0]  s_rresp = 0, s_bresp = 0;
  logic s_arvalid, s_arready = 1, s_rvalid = 0, s_rready, s_awvalid, s_awready = 0;
  logic s_wvalid, s_wready = 0, s_bvalid = 0, s_bready, grant, busy;
  int runs = 0, fails = 0;

  always #5 clk = ~clk;

  axi_lite_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .m0_araddr(m0_araddr), .m0_arprot(m0_arprot), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m0_awaddr(m0_awaddr), .m0_awprot(m0_awprot), .m0_awvalid(m0_awvalid), .m0_awready(m0_awready),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wvalid(m0_wvalid), .m0_wready(m0_wready),
    .m0_bresp(m0_bresp), .m0_bvalid(m0_bvalid), .m0_bready(m0_bready),
    .m1_araddr(m1_araddr), .m1_arprot(m1_arprot), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .m1_awaddr(m1_awaddr), .m1_awprot(m1_awprot), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
    .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
    .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .grant(grant), .busy(busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    runs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic serve_read(input logic m, input logic [31:0] addr, input logic [31:0] data,
                            input logic [1:0] resp);
    int k = 0;
    while (!s_arvalid && k < 4) begin
      step();
      k++;
    end
    chk("ar_fwd", 32'(s_arvalid), 1);
    chk("ar_grant", 32'(grant), 32'(m));
    chk("ar_addr", s_araddr, addr);
    chk("ar_ready_own", 32'(m ? m1_arready : m0_arready), 1);
    chk("ar_ready_other", 32'(m ? m0_arready : m1_arready), 0);
    step();
    if (m) m1_arvalid = 0; else m0_arvalid = 0;
    s_rvalid = 1; s_rdata = data; s_rresp = resp;
    #1;
    chk("r_valid_own", 32'(m ? m1_rvalid : m0_rvalid), 1);
    chk("r_valid_other", 32'(m ? m0_rvalid : m1_rvalid), 0);
    chk("r_data", m ? m1_rdata : m0_rdata, data);
    chk("r_resp", 32'(m ? m1_rresp : m0_rresp), 32'(resp));
    step();
    s_rvalid = 0;
  endtask

  initial begin
    step(); step();
    rst = 0;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_s_valids", {29'b0, s_arvalid, s_awvalid, s_wvalid}, 0);
    chk("rst_s_readies", {30'b0, s_rready, s_bready}, 3);
    chk("rst_m_readies", {26'b0, m0_arready, m0_awready, m0_wready, m1_arready, m1_awready, m1_wready}, 0);
    // simultaneous reads right after reset: m0 first, then m1
    m0_arvalid = 1; m0_araddr = 32'h100; m1_arvalid = 1; m1_araddr = 32'h200;
    step();
    serve_read(0, 32'h100, 32'h1111_0000, RESP_OKAY);
    serve_read(1, 32'h200, 32'h2222_0000, RESP_OKAY);
    chk("contend1_idle", 32'(busy), 0);
    // single m0 read, latency check
    m0_arvalid = 1; m0_araddr = 32'h0000_bff8;
    #1;
    chk("lat_idle_no_fwd", 32'(s_arvalid), 0);
    step();
    chk("lat_fwd_next", 32'(s_arvalid), 1);
    serve_read(0, 32'h0000_bff8, 32'h1234_5678, RESP_OKAY);
    chk("rd_free", 32'(busy), 0);
    // contention again after m0 was served last: m1 wins
    m0_arvalid = 1; m0_araddr = 32'h300; m1_arvalid = 1; m1_araddr = 32'h400;
    step();
    serve_read(1, 32'h400, 32'h4444_0000, RESP_OKAY);
    serve_read(0, 32'h300, 32'h3333_0000, RESP_OKAY);
    // m1 write, slave takes W one cycle before AW
    s_wready = 1; s_awready = 0;
    m1_awvalid = 1; m1_awaddr = 32'h4000; m1_wvalid = 1; m1_wdata = 32'hdeadbeef; m1_wstrb = 4'hf;
    step();
    chk("wr_grant", 32'(grant), 1);
    chk("wr_awvalid", 32'(s_awvalid), 1);
    chk("wr_wvalid", 32'(s_wvalid), 1);
    chk("wr_awaddr", s_awaddr, 32'h4000);
    chk("wr_wdata", s_wdata, 32'hdeadbeef);
    chk("wr_wstrb", 32'(s_wstrb), 32'hf);
    chk("wr_m1_wready", 32'(m1_wready), 1);
    chk("wr_m0_wready", 32'(m0_wready), 0);
    step();
    m1_wvalid = 0;
    chk("wr_w_masked", 32'(s_wvalid), 0);
    chk("wr_aw_still", 32'(s_awvalid), 1);
    s_awready = 1;
    #1;
    chk("wr_m1_awready", 32'(m1_awready), 1);
    step();
    m1_awvalid = 0; s_awready = 0;
    s_bvalid = 1; s_bresp = RESP_OKAY;
    #1;
    chk("wr_b_m1", 32'(m1_bvalid), 1);
    chk("wr_b_m0", 32'(m0_bvalid), 0);
    chk("wr_bresp", 32'(m1_bresp), 32'(RESP_OKAY));
    step();
    s_bvalid = 0;
    chk("wr_done_idle", 32'(busy), 0);
    // m0 read and write together: write first
    s_awready = 1; s_wready = 1;
    m0_arvalid = 1; m0_araddr = 32'h20;
    m0_awvalid = 1; m0_awaddr = 32'h24; m0_wvalid = 1; m0_wdata = 32'h55; m0_wstrb = 4'h3;
    step();
    chk("rw_write_first", 32'(s_awvalid), 1);
    chk("rw_no_read", 32'(s_arvalid), 0);
    step();
    m0_awvalid = 0; m0_wvalid = 0;
    s_bvalid = 1; s_bresp = RESP_SLVERR;
    #1;
    chk("rw_bvalid", 32'(m0_bvalid), 1);
    chk("rw_bresp", 32'(m0_bresp), 32'(RESP_SLVERR));
    step();
    s_bvalid = 0;
    serve_read(0, 32'h20, 32'hcafe_f00d, RESP_OKAY);
    // SLVERR passes through
    m0_arvalid = 1; m0_araddr = 32'h8;
    serve_read(0, 32'h8, 32'h0, RESP_SLVERR);
    // reset in the middle of RD_DATA
    m0_arvalid = 1; m0_araddr = 32'h10;
    step(); step();
    m0_arvalid = 0;
    chk("rstmid_busy", 32'(busy), 1);
    rst = 1;
    step();
    s_rvalid = 1; s_rdata = 32'h9999;
    #1;
    chk("rstmid_idle", 32'(busy), 0);
    chk("rstmid_no_r", {30'b0, m0_rvalid, m1_rvalid}, 0);
    chk("rstmid_sink", 32'(s_rready), 1);
    rst = 0; s_rvalid = 0;
    step();
`ifdef ARB_TIMEOUT_EN
    begin
      int k = 0;
      m0_arvalid = 1; m0_araddr = 32'hf00;
      step(); step();
      m0_arvalid = 0;
      while (!m0_rvalid && k < 20) begin
        step();
        k++;
      end
      chk("to_cycles", 32'(k), 8);
      chk("to_rresp", 32'(m0_rresp), 32'(RESP_DECERR));
      chk("to_rdata", m0_rdata, 0);
      step();
      chk("to_idle", 32'(busy), 0);
      s_rvalid = 1; s_rdata = 32'h77;
      #1;
      chk("to_late_sunk", 32'(s_rready), 1);
      chk("to_late_hidden", 32'(m0_rvalid), 0);
      step();
      s_rvalid = 0;
      chk("to_still_idle", 32'(busy), 0);
    end
`endif
    $display("[TB] %0d tests run, %0d failed", runs, fails);
    $finish;
  end
endmodule
